// File: rtl/sdc_rx_upscaler_if.sv
// Byte-in / word-out stream bundle for the SD receive upscaler.
// master = environment (byte source, word sink); slave = upscaler.
interface sdc_rx_upscaler_if;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_last_in;
  logic        rx_ready_in;
  logic [31:0] rx_data_out;
  logic        rx_last_out;
  logic        rx_valid_out;
  logic        rx_ready_out;

  modport master (
    output rx_data_in, rx_valid_in, rx_last_in, rx_ready_out,
    input  rx_ready_in, rx_data_out, rx_last_out, rx_valid_out
  );

  modport slave (
    input  rx_data_in, rx_valid_in, rx_last_in, rx_ready_out,
    output rx_ready_in, rx_data_out, rx_last_out, rx_valid_out
  );
endinterface

// File: rtl/sdc_rx_upscaler.sv
// SD receive 8->32 upscaler: little-endian packing, block/transfer framing, one-cycle word latency.
// Byte input stalls only on an emitting byte while the output word is stalled; SDC_RX_LENCHK_EN enables rx_last_in length checking.
module sdc_rx_upscaler #(
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLKSIZE_W-1:0] block_size,
  input  logic [BLKCNT_W-1:0]  block_cnt,
  sdc_rx_upscaler_if.slave     bus,
  output logic                 rx_finish,
  output logic                 rx_error
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [BLKSIZE_W-1:0] BS_ONE = 1;
  localparam logic [BLKCNT_W-1:0]  BC_ONE = 1;

  state_t                state, state_nxt;
  logic [BLKSIZE_W-1:0]  bsize_q;
  logic [BLKCNT_W-1:0]   bcnt_q;
  logic [BLKSIZE_W-1:0]  byte_counter;
  logic [BLKCNT_W-1:0]   block_counter;
  logic [1:0]            offset;
  logic [23:0]           acc;
  logic [31:0]           out_data;
  logic                  out_last;
  logic                  out_valid;
  logic                  finish_q;

  logic                  blk_end;
  logic                  blk_final;
  logic                  emit;
  logic                  out_hs;
  logic                  out_stall;
  logic                  ready;
  logic                  byte_fire;
  logic [31:0]           word;

  always_comb begin
    blk_end   = (byte_counter == bsize_q);
    blk_final = blk_end && (block_counter == bcnt_q);
    emit      = (offset == 2'd3) || blk_end;
    out_hs    = out_valid && bus.rx_ready_out;
    out_stall = out_valid && !bus.rx_ready_out;
    // Only a byte that would overwrite a stalled word has to wait.
    ready     = (state == RUN) && !(emit && out_stall);
    byte_fire = bus.rx_valid_in && ready;
  end

  // Accumulator lanes above offset are always zero, giving the zero padding for free.
  always_comb begin
    word = 32'd0;
    case (offset)
      2'd0:    word = {24'd0, bus.rx_data_in};
      2'd1:    word = {16'd0, bus.rx_data_in, acc[7:0]};
      2'd2:    word = {8'd0, bus.rx_data_in, acc[15:0]};
      default: word = {bus.rx_data_in, acc[23:0]};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (byte_fire && blk_final) state_nxt = DRAIN;
      DRAIN:   if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bsize_q       <= '0;
      bcnt_q        <= '0;
      byte_counter  <= '0;
      block_counter <= '0;
      offset        <= 2'd0;
      acc           <= 24'd0;
      out_data      <= 32'd0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      finish_q <= (state == DRAIN) && out_hs;

      if (state == IDLE && start) begin
        bsize_q       <= block_size;
        bcnt_q        <= block_cnt;
        byte_counter  <= '0;
        block_counter <= '0;
        offset        <= 2'd0;
        acc           <= 24'd0;
      end else if (byte_fire) begin
        if (emit) begin
          offset <= 2'd0;
          acc    <= 24'd0;
        end else begin
          offset <= offset + 2'd1;
          case (offset)
            2'd0:    acc[7:0]   <= bus.rx_data_in;
            2'd1:    acc[15:8]  <= bus.rx_data_in;
            default: acc[23:16] <= bus.rx_data_in;
          endcase
        end
        if (blk_end) begin
          byte_counter <= '0;
          if (!blk_final) block_counter <= block_counter + BC_ONE;
        end else begin
          byte_counter <= byte_counter + BS_ONE;
        end
      end

      // A reload in the handshake cycle replaces the old word with no bubble.
      if (byte_fire && emit) begin
        out_data  <= word;
        out_last  <= blk_end;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SDC_RX_LENCHK_EN
  logic err_q;

  // Framing follows the internal count; the receiver's marker is only audited.
  always_ff @(posedge clk) begin
    if (rst)                                          err_q <= 1'b0;
    else if (state == IDLE && start)                  err_q <= 1'b0;
    else if (byte_fire && (bus.rx_last_in != blk_end)) err_q <= 1'b1;
  end

  assign rx_error = err_q;
`else
  logic unused_last_in;

  assign unused_last_in = bus.rx_last_in;
  assign rx_error       = 1'b0;
`endif

  assign bus.rx_ready_in  = ready;
  assign bus.rx_data_out  = out_data;
  assign bus.rx_last_out  = out_last;
  assign bus.rx_valid_out = out_valid;
  assign rx_finish        = finish_q;

endmodule

// File: doc/sdc_rx_upscaler.md
# sdc_rx_upscaler

Receive-path 1-byte to 4-byte upscaler for the SD controller data line, sitting between the SD data receiver (byte stream plus per-block last marker) and the 32-bit DMA/FIFO stream. It packs bytes little-endian into words and counts bytes and blocks against the programmed transfer size. It marks the last word of each block and signals completion of the whole transfer. It also flushes zero-padded partial words at block ends.

## Interface
- BLKSIZE_W, 12: width of block_size / byte counter.
- BLKCNT_W, 16: width of block_cnt / block counter.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a transfer (honoured only in IDLE).
- block_size  in  BLKSIZE_W  bytes per block minus 1; sampled on accepted start.
- block_cnt  in  BLKCNT_W  blocks per transfer minus 1; sampled on accepted start.
- rx_data_in  in  8  byte from SD data receiver.
- rx_valid_in  in  1  byte valid.
- rx_last_in  in  1  receiver's last-byte-of-block marker.
- rx_ready_in  out  1  byte accepted when rx_valid_in && rx_ready_in.
- rx_data_out  out  32  packed word; first byte in [7:0].
- rx_last_out  out  1  word is the final word of a block.
- rx_valid_out  out  1  output word valid.
- rx_ready_out  in  1  downstream ready.
- rx_finish  out  1  one-cycle pulse: transfer complete.
- rx_error  out  1  sticky length-mismatch flag (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: rx_ready_in=0. On start: latch block_size/block_cnt, clear byte_counter, block_counter, offset, go RUN. start is ignored in RUN/DRAIN.
- RUN: each accepted byte is written to lane `offset` of the accumulator; offset increments mod 4; byte_counter increments.
- Word emit: on an accepted byte with offset==3 or byte_counter==block_size, load accumulator (with this byte) into the output register, set rx_valid_out. Lanes above the current offset are zero. Reset offset to 0 and clear the accumulator.
- Block end (byte_counter==block_size on accepted byte): rx_last_out=1 on that word; byte_counter->0. If block_counter==block_cnt, go DRAIN; else block_counter+1.
- DRAIN: rx_ready_in=0. When the output word handshakes, pulse rx_finish and go IDLE.
- Backpressure: rx_ready_in = (state==RUN) && !(emitting byte && rx_valid_out && !rx_ready_out). Non-emitting bytes are always accepted. This gives full byte throughput.
- Output register holds data/last stable while rx_valid_out && !rx_ready_out; clears valid on handshake unless reloaded the same cycle.
- rst at any time: all state cleared, return to IDLE; any in-flight word is discarded.

## Timing
- Reset values: rx_ready_in=0, rx_valid_out=0, rx_data_out=0, rx_last_out=0, rx_finish=0, rx_error=0, state=IDLE.
- start at cycle n -> rx_ready_in=1 at n+1 (if no rst).
- Emitting byte accepted at cycle n -> rx_valid_out=1 at n+1.
- Final word handshake at cycle m -> rx_finish=1 during m+1 only, state IDLE at m+1; start is accepted from m+1.
- Simultaneous output handshake and new word load: the new word replaces the old one with no bubble.
- Counters compare equality only; block_size=0 gives 1-byte blocks, each emitted as word 0x000000XX with last=1.

## Configuration
- SDC_RX_LENCHK_EN defined: on each accepted byte, rx_last_in != (byte_counter==block_size) sets rx_error. It stays set until rst or accepted start. The internal count always governs framing.
- Undefined: rx_last_in ignored, rx_error tied 0, no compare logic.

## Test plan
- block_size=511, block_cnt=0, bytes i&0xFF continuous, rx_ready_out=1 -> 128 words, first 0x03020100, rx_last_out only on word 128 (0xFFFEFDFC), rx_finish one cycle after its handshake.
- block_size=5, block_cnt=1, bytes 0x11..0x1C -> words 0x14131211, 0x00001615(last), 0x1A191817, 0x00001C1B(last), then rx_finish.
- rx_ready_out held 0 for 10 cycles mid-block -> rx_ready_in drops on the next emitting byte, rx_data_out stable, no byte lost or duplicated after release.
- rst asserted in RUN after 6 bytes -> next cycle all outputs at reset values; a fresh start with a 4-byte block yields a correct single word.
- With SDC_RX_LENCHK_EN, block_size=7, rx_last_in asserted on byte 4 -> rx_error=1 and stays 1. Framing still emits 2 words with last on word 2. A new start clears rx_error.
- start pulsed during RUN -> ignored: counters unchanged, transfer completes normally.
